mips_bus_arbiter: RTL and testbench

Shares the CPU's single Avalon memory-mapped master port between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read or write with byte enables). Arbitrates one transaction at a time, holds bus signals stable across waitrequest stalls and captures readdata in the cycle after acceptance. Returns a one-cycle done pulse to the owning requester. Sits between the mips_cpu_bus control FSM and the top-level Avalon ports.

---
 rtl/mips_bus_pkg.sv | 22 ++
 rtl/mips_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS CPU Avalon bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  typedef enum logic {
    GNT_IFETCH = 1'b0,
    GNT_DMEM   = 1'b1
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // The Avalon port is word addressed in bytes: low two bits are always zero.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) onto one Avalon master.
// One transaction at a time: IDLE grant -> ACCESS until accepted -> RESP done pulse.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int DMEM_PRIORITY = 1,
  parameter int WAIT_TIMEOUT  = 1024,
  parameter int TO_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic        ifetch_done,
  output logic [31:0] ifetch_rdata,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic        dmem_done,
  output logic [31:0] dmem_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        timeout
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(WAIT_TIMEOUT);

  bus_state_t      r_state, w_next;
  grant_t          r_owner, w_gnt;
  logic            r_we;
  logic            r_read, r_write;
  logic [31:0]     r_address, r_writedata;
  logic [3:0]      r_byteenable;
  logic [31:0]     r_ifetch_rdata, r_dmem_rdata;
  logic [TO_W-1:0] r_stall_cnt, w_stall_nxt;
  logic            r_timeout;
  logic            w_any_req, w_stall, w_resp_i, w_resp_d;

  assign w_any_req = ifetch_req | dmem_req;
  assign w_gnt     = (dmem_req && (DMEM_PRIORITY != 0 || !ifetch_req)) ? GNT_DMEM : GNT_IFETCH;
  assign w_stall   = (r_state == ACCESS) && waitrequest;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req)    w_next = ACCESS;
      ACCESS:  if (!waitrequest) w_next = RESP;
      RESP:                      w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
  end

  // Bus output registers: loaded at grant, frozen through ACCESS stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner        <= GNT_IFETCH;
      r_we           <= 1'b0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_address      <= '0;
      r_writedata    <= '0;
      r_byteenable   <= '0;
      r_ifetch_rdata <= '0;
      r_dmem_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_gnt;
            if (w_gnt == GNT_DMEM) begin
              r_we         <= dmem_we;
              r_read       <= !dmem_we;
              r_write      <= dmem_we;
              r_address    <= word_align(dmem_addr);
              r_writedata  <= dmem_wdata;
              r_byteenable <= dmem_be;
            end else begin
              r_we         <= 1'b0;
              r_read       <= 1'b1;
              r_write      <= 1'b0;
              r_address    <= word_align(ifetch_addr);
              r_writedata  <= '0;
              r_byteenable <= BE_WORD;
            end
          end else begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_byteenable <= '0;
          end
        end
        ACCESS: begin
          if (!waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
          end
        end
        RESP: begin
          r_byteenable <= '0;
          if (!r_we) begin
            if (r_owner == GNT_IFETCH) r_ifetch_rdata <= readdata;
            else                       r_dmem_rdata   <= readdata;
          end
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  // Stall counter saturates so a hung slave cannot wrap it back under the limit.
  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if (w_stall && !(&r_stall_cnt)) w_stall_nxt = r_stall_cnt + 1'b1;
    else if (r_state != ACCESS)     w_stall_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
      if (WAIT_TIMEOUT != 0 && w_stall && w_stall_nxt == TO_LIM) r_timeout <= 1'b1;
    end
  end

  // Outputs: done and read data bypass are combinational in RESP.
  assign w_resp_i = (r_state == RESP) && (r_owner == GNT_IFETCH);
  assign w_resp_d = (r_state == RESP) && (r_owner == GNT_DMEM);

  always_comb begin
    busy         = (r_state != IDLE);
    ifetch_done  = w_resp_i;
    dmem_done    = w_resp_d;
    ifetch_rdata = (w_resp_i && !r_we) ? readdata : r_ifetch_rdata;
    dmem_rdata   = (w_resp_d && !r_we) ? readdata : r_dmem_rdata;
  end

  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: dut0 (dmem priority, timeout 4), dut1 (fetch priority).
module tb_mips_bus_arbiter;

  typedef struct {
    bit          d;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        ifetch_req = 1'b0, dmem_req = 1'b0, dmem_we = 1'b0;
  logic        p0_ifetch_req = 1'b0, p0_dmem_req = 1'b0;
  logic [31:0] ifetch_addr = '0, dmem_addr = '0, dmem_wdata = '0;
  logic [3:0]  dmem_be = '0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata, rd_drive = '0, acc_addr = '0;
  bit          slave_auto = 1'b0;

  logic        ifetch_done, dmem_done, read, write, busy, timeout;
  logic [31:0] ifetch_rdata, dmem_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        d1_ifetch_done, d1_dmem_done, d1_read, d1_write, d1_busy, d1_timeout;
  logic [31:0] d1_ifetch_rdata, d1_dmem_rdata, d1_address, d1_writedata;
  logic [3:0]  d1_byteenable;

  int   n_chk = 0, n_err = 0;
  exp_t exp_q[$];
  logic [31:0] m_irdata = '0, m_drdata = '0;

  mips_bus_arbiter #(.DMEM_PRIORITY(1), .WAIT_TIMEOUT(4), .TO_W(11)) dut0 (
    .clk(clk), .reset(reset),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_done(ifetch_done), .ifetch_rdata(ifetch_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_done(dmem_done), .dmem_rdata(dmem_rdata),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .busy(busy), .timeout(timeout));

  mips_bus_arbiter #(.DMEM_PRIORITY(0), .WAIT_TIMEOUT(1024), .TO_W(11)) dut1 (
    .clk(clk), .reset(reset),
    .ifetch_req(p0_ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_done(d1_ifetch_done), .ifetch_rdata(d1_ifetch_rdata),
    .dmem_req(p0_dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_done(d1_dmem_done), .dmem_rdata(d1_dmem_rdata),
    .address(d1_address), .read(d1_read), .write(d1_write), .waitrequest(waitrequest), .writedata(d1_writedata),
    .byteenable(d1_byteenable), .readdata(readdata), .busy(d1_busy), .timeout(d1_timeout));

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // Avalon slave model: returns data for the address it accepted on the previous edge.
  always @(posedge clk) begin
    if (read && !waitrequest)         acc_addr <= address;
    else if (d1_read && !waitrequest) acc_addr <= d1_address;
  end
  always_comb readdata = slave_auto ? mem(acc_addr) : rd_drive;

  always @(negedge clk) begin
    if (!reset) begin
      n_chk++; if (read && write) begin n_err++; $display("FAIL rw_exclusive got read=%0b write=%0b exp not both", read, write); end
      n_chk++; if (ifetch_done && dmem_done) begin n_err++; $display("FAIL done_exclusive got both done exp at most one"); end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc(); #1;
    n_chk++; if ({read, write, busy, timeout, ifetch_done, dmem_done} !== 6'b0) begin n_err++; $display("FAIL reset_ctl got %b exp 000000", {read, write, busy, timeout, ifetch_done, dmem_done}); end
    n_chk++; if ({address, writedata, byteenable} !== 68'h0) begin n_err++; $display("FAIL reset_bus got %h exp 0", {address, writedata, byteenable}); end
    n_chk++; if ({ifetch_rdata, dmem_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", {ifetch_rdata, dmem_rdata}); end
    n_chk++; if ({d1_read, d1_write, d1_busy, d1_timeout, d1_byteenable} !== 8'h0) begin n_err++; $display("FAIL reset_dut1 got %h exp 0", {d1_read, d1_write, d1_busy, d1_timeout, d1_byteenable}); end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    cyc(); slave_auto = 0; waitrequest = 0; ifetch_req = 1; ifetch_addr = 32'hBFC0_0000;
    exp_q.push_back('{1'b0, 32'h2402_0005});
    cyc(); #1;
    n_chk++; if ({read, write} !== 2'b10) begin n_err++; $display("FAIL fetch_rw got %b exp 10", {read, write}); end
    n_chk++; if (address !== 32'hBFC0_0000) begin n_err++; $display("FAIL fetch_addr got %h exp bfc00000", address); end
    n_chk++; if (byteenable !== 4'hF || busy !== 1'b1) begin n_err++; $display("FAIL fetch_be_busy got be=%h busy=%b exp f 1", byteenable, busy); end
    cyc(); rd_drive = 32'h2402_0005; #1;
    e = exp_q.pop_front();
    n_chk++; if ({dmem_done, ifetch_done} !== (e.d ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL fetch_done got %b exp %b", {dmem_done, ifetch_done}, e.d ? 2'b10 : 2'b01); end
    n_chk++; if (ifetch_rdata !== e.rdata) begin n_err++; $display("FAIL fetch_rdata got %h exp %h", ifetch_rdata, e.rdata); end
    m_irdata = e.rdata; ifetch_req = 0;
    cyc(); rd_drive = 32'h0; #1;
    n_chk++; if (busy !== 1'b0 || ifetch_done !== 1'b0) begin n_err++; $display("FAIL fetch_idle got busy=%b done=%b exp 0 0", busy, ifetch_done); end
    n_chk++; if (ifetch_rdata !== m_irdata) begin n_err++; $display("FAIL fetch_hold got %h exp %h", ifetch_rdata, m_irdata); end
  endtask

  task automatic test_load();
    exp_t e;
    cyc(); slave_auto = 1; waitrequest = 1; dmem_req = 1; dmem_we = 0; dmem_addr = 32'h0000_2003; dmem_be = 4'b0011;
    exp_q.push_back('{1'b1, mem(32'h0000_2000)});
    cyc(); #1;
    n_chk++; if ({read, write, address, byteenable} !== {2'b10, 32'h0000_2000, 4'b0011}) begin n_err++; $display("FAIL load_bus got %b %h %h exp 10 00002000 3", {read, write}, address, byteenable); end
    cyc(); waitrequest = 0; #1;
    n_chk++; if (read !== 1'b1 || dmem_done !== 1'b0) begin n_err++; $display("FAIL load_stall got read=%b done=%b exp 1 0", read, dmem_done); end
    cyc(); #1;
    e = exp_q.pop_front();
    n_chk++; if ({dmem_done, ifetch_done} !== (e.d ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL load_done got %b exp %b", {dmem_done, ifetch_done}, e.d ? 2'b10 : 2'b01); end
    n_chk++; if (dmem_rdata !== e.rdata) begin n_err++; $display("FAIL load_rdata got %h exp %h", dmem_rdata, e.rdata); end
    m_drdata = e.rdata; dmem_req = 0;
    cyc(); slave_auto = 0; rd_drive = 32'h1111_1111; #1;
    n_chk++; if (dmem_rdata !== m_drdata || ifetch_rdata !== m_irdata) begin n_err++; $display("FAIL load_hold got %h %h exp %h %h", dmem_rdata, ifetch_rdata, m_drdata, m_irdata); end
  endtask

  task automatic test_store();
    exp_t e;
    cyc(); waitrequest = 1; dmem_req = 1; dmem_we = 1; dmem_addr = 32'h0000_1006; dmem_wdata = 32'hDEAD_BEEF; dmem_be = 4'b1100;
    exp_q.push_back('{1'b1, m_drdata});
    for (int k = 1; k <= 4; k++) begin
      cyc(); if (k == 4) waitrequest = 0; #1;
      n_chk++; if ({read, write, address, writedata, byteenable} !== {2'b01, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1100})
        begin n_err++; $display("FAIL store_bus_c%0d got %b %h %h %h exp 01 00001004 deadbeef c", k, {read, write}, address, writedata, byteenable); end
      n_chk++; if (dmem_done !== 1'b0) begin n_err++; $display("FAIL store_early_done_c%0d got 1 exp 0", k); end
    end
    cyc(); #1;
    e = exp_q.pop_front();
    n_chk++; if ({dmem_done, ifetch_done, write} !== {(e.d ? 2'b10 : 2'b01), 1'b0}) begin n_err++; $display("FAIL store_done got %b exp %b0", {dmem_done, ifetch_done, write}, e.d ? 2'b10 : 2'b01); end
    n_chk++; if (dmem_rdata !== e.rdata) begin n_err++; $display("FAIL store_rdata got %h exp %h", dmem_rdata, e.rdata); end
    dmem_req = 0; dmem_we = 0;
    cyc(); #1;
    n_chk++; if (dmem_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL store_single got done=%b busy=%b exp 0 0", dmem_done, busy); end
  endtask

  // lo=0 drives dut0 (dmem wins), lo=1 drives dut1 (fetch wins).
  task automatic test_priority(input bit lo);
    exp_t e;
    int t_i, t_d;
    logic idn, ddn;
    logic [31:0] ird, drd;
    t_i = -1; t_d = -1;
    cyc(); slave_auto = 1; waitrequest = 0; ifetch_addr = 32'h0000_0100; dmem_addr = 32'h0000_0208; dmem_we = 0; dmem_be = 4'hF;
    if (lo) begin
      p0_ifetch_req = 1; p0_dmem_req = 1;
      exp_q.push_back('{1'b0, mem(32'h100)}); exp_q.push_back('{1'b1, mem(32'h208)});
    end else begin
      ifetch_req = 1; dmem_req = 1;
      exp_q.push_back('{1'b1, mem(32'h208)}); exp_q.push_back('{1'b0, mem(32'h100)});
    end
    for (int c = 1; c <= 12; c++) begin
      cyc(); #1;
      idn = lo ? d1_ifetch_done : ifetch_done;   ddn = lo ? d1_dmem_done : dmem_done;
      ird = lo ? d1_ifetch_rdata : ifetch_rdata; drd = lo ? d1_dmem_rdata : dmem_rdata;
      if (idn || ddn) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL prio%0d_extra_done got done at c%0d exp none", lo, c); end
        else begin
          e = exp_q.pop_front();
          if ({ddn, idn} !== (e.d ? 2'b10 : 2'b01) || (e.d ? drd : ird) !== e.rdata) begin
            n_err++; $display("FAIL prio%0d_done got %b %h exp %b %h", lo, {ddn, idn}, e.d ? drd : ird, e.d ? 2'b10 : 2'b01, e.rdata);
          end
          if (!lo) begin if (e.d) m_drdata = e.rdata; else m_irdata = e.rdata; end
        end
        if (idn) begin t_i = c; ifetch_req = 0; p0_ifetch_req = 0; end
        if (ddn) begin t_d = c; dmem_req = 0; p0_dmem_req = 0; end
      end
    end
    n_chk++; if ((lo ? t_i : t_d) != 2) begin n_err++; $display("FAIL prio%0d_first got %0d exp 2", lo, lo ? t_i : t_d); end
    n_chk++; if ((lo ? t_d : t_i) != 5) begin n_err++; $display("FAIL prio%0d_second got %0d exp 5", lo, lo ? t_d : t_i); end
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL prio%0d_pending got %0d exp 0", lo, exp_q.size()); end
    ifetch_req = 0; dmem_req = 0; p0_ifetch_req = 0; p0_dmem_req = 0; exp_q.delete();
  endtask

  task automatic test_timeout();
    exp_t e;
    cyc(); slave_auto = 1; waitrequest = 1; ifetch_req = 1; ifetch_addr = 32'h0000_0300;
    exp_q.push_back('{1'b0, mem(32'h300)});
    for (int k = 1; k <= 7; k++) begin
      cyc(); #1;
      n_chk++; if ({read, timeout} !== {1'b1, (k >= 5)}) begin n_err++; $display("FAIL timeout_c%0d got read=%b to=%b exp 1 %b", k, read, timeout, k >= 5); end
    end
    cyc(); waitrequest = 0; #1;
    n_chk++; if (read !== 1'b1 || ifetch_done !== 1'b0) begin n_err++; $display("FAIL timeout_held got read=%b done=%b exp 1 0", read, ifetch_done); end
    cyc(); #1;
    e = exp_q.pop_front();
    n_chk++; if (ifetch_done !== 1'b1 || ifetch_rdata !== e.rdata) begin n_err++; $display("FAIL timeout_done got %b %h exp 1 %h", ifetch_done, ifetch_rdata, e.rdata); end
    m_irdata = e.rdata; ifetch_req = 0;
    cyc(); cyc(); #1;
    n_chk++; if (timeout !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL timeout_sticky got to=%b busy=%b exp 1 0", timeout, busy); end
  endtask

  task automatic test_reset_midstall();
    exp_t e;
    bit seen;
    cyc(); slave_auto = 1; waitrequest = 1; ifetch_req = 1; ifetch_addr = 32'h0000_0400;
    exp_q.push_back('{1'b0, mem(32'h400)});
    cyc(); #1;
    n_chk++; if (read !== 1'b1) begin n_err++; $display("FAIL rst_pre_read got %b exp 1", read); end
    cyc(); reset = 1;
    cyc(); reset = 0; ifetch_req = 0; waitrequest = 0; #1;
    exp_q.delete();
    n_chk++; if ({read, write, busy, ifetch_done, dmem_done, timeout} !== 6'b0) begin n_err++; $display("FAIL rst_mid got %b exp 000000", {read, write, busy, ifetch_done, dmem_done, timeout}); end
    seen = 0;
    for (int k = 0; k < 3; k++) begin cyc(); #1; if (ifetch_done || dmem_done || busy) seen = 1; end
    n_chk++; if (seen) begin n_err++; $display("FAIL rst_no_done got activity exp none"); end
    ifetch_addr = 32'h0000_0502; ifetch_req = 1;
    exp_q.push_back('{1'b0, mem(32'h500)});
    cyc(); #1;
    n_chk++; if ({read, address} !== {1'b1, 32'h0000_0500}) begin n_err++; $display("FAIL rst_after_bus got %b %h exp 1 00000500", read, address); end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc(); #1;
      if (ifetch_done) begin
        seen = 1; e = exp_q.pop_front();
        n_chk++; if (ifetch_rdata !== e.rdata || k != 0) begin n_err++; $display("FAIL rst_after_done got %h at +%0d exp %h at +0", ifetch_rdata, k, e.rdata); end
        ifetch_req = 0;
      end
    end
    n_chk++; if (!seen) begin n_err++; $display("FAIL rst_after_timeout got no done exp done"); end
    ifetch_req = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_priority(1'b0);
    test_priority(1'b1);
    test_timeout();
    test_reset_midstall();
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
